// File: rtl/axi4_lite_slave_regs_if.sv
// AXI4-Lite bus bundle for the register slave: five channels, master and slave views.
interface axi4_lite_slave_regs_if;
  logic [31:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, input S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
    input S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARVALID, input S_AXI_ARREADY,
    input S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY
  );

  modport slave (
    input S_AXI_AWADDR, S_AXI_AWVALID, output S_AXI_AWREADY,
    input S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID, input S_AXI_BREADY,
    input S_AXI_ARADDR, S_AXI_ARVALID, output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, input S_AXI_RREADY
  );
endinterface

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers with byte strobes.
// Write and read paths are independent FSMs; out-of-range accesses answer SLVERR.
module axi4_lite_slave_regs #(
  parameter int NUM_REGS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  axi4_lite_slave_regs_if.slave    axi,
  output logic [NUM_REGS*32-1:0]   Reg_Out,
  output logic                     Wr_Pulse,
  output logic [3:0]               Wr_Index
);

  localparam logic [31:0] ADDR_LIMIT = 32'(NUM_REGS * 4);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic {W_COLLECT, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e    w_state_q;
  r_state_e    r_state_q;
  logic        aw_held_q;
  logic        w_held_q;
  logic [31:0] awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        wr_pulse_q;
  logic [3:0]  wr_index_q;

  logic        aw_ready;
  logic        w_ready;
  logic        ar_ready;
  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic        commit;
  logic        commit_hit;
  logic [3:0]  wr_idx;
  logic [3:0]  rd_idx;
  logic        rd_hit;
  logic [31:0] rd_word;

  // Readies are gated by rst so nothing is accepted while reset is held.
  assign aw_ready = (w_state_q == W_COLLECT) && !aw_held_q && !rst;
  assign w_ready  = (w_state_q == W_COLLECT) && !w_held_q && !rst;
  assign ar_ready = (r_state_q == R_IDLE) && !rst;

  assign aw_hs = axi.S_AXI_AWVALID && aw_ready;
  assign w_hs  = axi.S_AXI_WVALID && w_ready;
  assign ar_hs = axi.S_AXI_ARVALID && ar_ready;

  assign commit     = (w_state_q == W_COLLECT) && aw_held_q && w_held_q;
  assign wr_idx     = awaddr_q[5:2];
  assign commit_hit = commit && (awaddr_q < ADDR_LIMIT);

  assign axi.S_AXI_AWREADY = aw_ready;
  assign axi.S_AXI_WREADY  = w_ready;
  assign axi.S_AXI_BVALID  = bvalid_q;
  assign axi.S_AXI_BRESP   = bresp_q;
  assign axi.S_AXI_ARREADY = ar_ready;
  assign axi.S_AXI_RVALID  = rvalid_q;
  assign axi.S_AXI_RDATA   = rdata_q;
  assign axi.S_AXI_RRESP   = rresp_q;
  assign Wr_Pulse          = wr_pulse_q;
  assign Wr_Index          = wr_index_q;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [31:0] reg_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        reg_q <= '0;
      end else if (commit_hit && (wr_idx == 4'(gi))) begin
        for (int k = 0; k < 4; k++) begin
          if (wstrb_q[k]) begin
            reg_q[8*k +: 8] <= wdata_q[8*k +: 8];
          end
        end
      end
    end

    assign Reg_Out[32*gi +: 32] = reg_q;
  end

  // Read mux sees pre-commit contents, so a same-edge read returns the old value.
  always_comb begin
    rd_idx  = axi.S_AXI_ARADDR[5:2];
    rd_hit  = axi.S_AXI_ARADDR < ADDR_LIMIT;
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == 4'(i)) begin
        rd_word = Reg_Out[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= W_COLLECT;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= 1'b0;
      wr_index_q <= '0;
    end else begin
      wr_pulse_q <= 1'b0;
      case (w_state_q)
        W_COLLECT: begin
          if (aw_hs) begin
            awaddr_q  <= axi.S_AXI_AWADDR;
            aw_held_q <= 1'b1;
          end
          if (w_hs) begin
            wdata_q  <= axi.S_AXI_WDATA;
            wstrb_q  <= axi.S_AXI_WSTRB;
            w_held_q <= 1'b1;
          end
          if (commit) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= commit_hit ? RESP_OKAY : RESP_SLVERR;
            w_state_q <= W_RESP;
            if (commit_hit) begin
              wr_pulse_q <= 1'b1;
              wr_index_q <= wr_idx;
            end
          end
        end
        W_RESP: begin
          if (axi.S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            w_state_q <= W_COLLECT;
          end
        end
        default: w_state_q <= W_COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_hit ? rd_word : 32'h0;
            rresp_q   <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi.S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Bench for axi4_lite_slave_regs: transaction-level model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_axi4_lite_slave_regs;
  localparam int NUM_REGS = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi4_lite_slave_regs_if axi ();
  logic [NUM_REGS*32-1:0] reg_out;
  logic                   wr_pulse;
  logic [3:0]             wr_index;

  axi4_lite_slave_regs #(.NUM_REGS(NUM_REGS)) dut (
    .clk      (clk),
    .rst      (rst),
    .axi      (axi),
    .Reg_Out  (reg_out),
    .Wr_Pulse (wr_pulse),
    .Wr_Index (wr_index)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkv(input string name, input logic [NUM_REGS*32-1:0] act,
                        input logic [NUM_REGS*32-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: registers as an array, accepted AW/W beats as queues.
  // At each falling edge the outputs are compared, then the model advances
  // by what the coming rising edge will see on the (stable) inputs.
  logic [31:0] m_regs [16];
  logic [31:0] aw_q [$];
  logic [35:0] w_q [$];
  bit          m_bvalid;
  logic [1:0]  m_bresp;
  bit          m_pulse;
  logic [3:0]  m_idx;
  bit          m_rvalid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  bit          started = 1'b0;

  initial begin : model
    logic [NUM_REGS*32-1:0] ev;
    bit aw_rdy, w_rdy, do_commit;
    logic [31:0] a;
    logic [35:0] wd;
    forever begin
      @(negedge clk);
      if (started) begin
        aw_rdy = !m_bvalid && (aw_q.size() == 0);
        w_rdy  = !m_bvalid && (w_q.size() == 0);
        check("m_awready", 32'(axi.S_AXI_AWREADY), 32'(!rst && aw_rdy));
        check("m_wready", 32'(axi.S_AXI_WREADY), 32'(!rst && w_rdy));
        check("m_arready", 32'(axi.S_AXI_ARREADY), 32'(!rst && !m_rvalid));
        check("m_bvalid", 32'(axi.S_AXI_BVALID), 32'(m_bvalid));
        if (m_bvalid) check("m_bresp", 32'(axi.S_AXI_BRESP), 32'(m_bresp));
        check("m_rvalid", 32'(axi.S_AXI_RVALID), 32'(m_rvalid));
        if (m_rvalid) begin
          check("m_rdata", axi.S_AXI_RDATA, m_rdata);
          check("m_rresp", 32'(axi.S_AXI_RRESP), 32'(m_rresp));
        end
        check("m_wr_pulse", 32'(wr_pulse), 32'(m_pulse));
        if (m_pulse) check("m_wr_index", 32'(wr_index), 32'(m_idx));
        for (int i = 0; i < NUM_REGS; i++) ev[32*i +: 32] = m_regs[i];
        checkv("m_reg_out", reg_out, ev);
      end
      if (rst) begin
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        aw_q.delete();
        w_q.delete();
        m_bvalid = 1'b0;
        m_bresp  = 2'b00;
        m_pulse  = 1'b0;
        m_idx    = '0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
        m_rresp  = 2'b00;
        started  = 1'b1;
      end else if (started) begin
        aw_rdy    = !m_bvalid && (aw_q.size() == 0);
        w_rdy     = !m_bvalid && (w_q.size() == 0);
        do_commit = !m_bvalid && (aw_q.size() != 0) && (w_q.size() != 0);
        if (!m_rvalid && axi.S_AXI_ARVALID) begin
          m_rvalid = 1'b1;
          if (axi.S_AXI_ARADDR < 32'(NUM_REGS * 4)) begin
            m_rdata = m_regs[axi.S_AXI_ARADDR[5:2]];
            m_rresp = 2'b00;
          end else begin
            m_rdata = '0;
            m_rresp = 2'b10;
          end
        end else if (m_rvalid && axi.S_AXI_RREADY) begin
          m_rvalid = 1'b0;
        end
        m_pulse = 1'b0;
        if (m_bvalid && axi.S_AXI_BREADY) begin
          m_bvalid = 1'b0;
        end else if (do_commit) begin
          a  = aw_q.pop_front();
          wd = w_q.pop_front();
          m_bvalid = 1'b1;
          if (a < 32'(NUM_REGS * 4)) begin
            for (int k = 0; k < 4; k++)
              if (wd[32+k]) m_regs[a[5:2]][8*k +: 8] = wd[8*k +: 8];
            m_bresp = 2'b00;
            m_pulse = 1'b1;
            m_idx   = a[5:2];
          end else begin
            m_bresp = 2'b10;
          end
        end
        if (aw_rdy && axi.S_AXI_AWVALID) aw_q.push_back(axi.S_AXI_AWADDR);
        if (w_rdy && axi.S_AXI_WVALID) w_q.push_back({axi.S_AXI_WSTRB, axi.S_AXI_WDATA});
      end
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int bready_dly, input bit bready_early,
                           output logic [1:0] bresp, output logic pulse,
                           output logic [3:0] idx);
    bit aw_done = 1'b0;
    bit w_done = 1'b0;
    bit hs_aw, hs_w;
    int cyc = 0;
    axi.S_AXI_BREADY = bready_early;
    while (!(aw_done && w_done) && cyc < 40) begin
      axi.S_AXI_AWADDR  = addr;
      axi.S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      axi.S_AXI_WDATA   = data;
      axi.S_AXI_WSTRB   = strb;
      axi.S_AXI_WVALID  = !w_done && (cyc >= w_dly);
      hs_aw = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      hs_w  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      tick();
      cyc++;
      if (hs_aw) aw_done = 1'b1;
      if (hs_w) w_done = 1'b1;
    end
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    check("aw_w_accepted", 32'({aw_done, w_done}), 32'h3);
    check("bvalid_before_commit", 32'(axi.S_AXI_BVALID), 32'h0);
    tick();
    check("bvalid_latency", 32'(axi.S_AXI_BVALID), 32'h1);
    bresp = axi.S_AXI_BRESP;
    pulse = wr_pulse;
    idx   = wr_index;
    if (!bready_early) begin
      repeat (bready_dly) tick();
      axi.S_AXI_BREADY = 1'b1;
    end
    tick();
    axi.S_AXI_BREADY = 1'b0;
    check("bvalid_after_b_hs", 32'(axi.S_AXI_BVALID), 32'h0);
    $display("[TB] write addr=%08h data=%08h strb=%h bresp=%0d pulse=%0d idx=%0d",
             addr, data, strb, bresp, pulse, idx);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int rready_dly,
                          output logic [31:0] rdata, output logic [1:0] rresp);
    bit done = 1'b0;
    bit hs;
    int cyc = 0;
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    while (!done && cyc < 40) begin
      hs = axi.S_AXI_ARVALID && axi.S_AXI_ARREADY;
      tick();
      cyc++;
      if (hs) done = 1'b1;
    end
    axi.S_AXI_ARVALID = 1'b0;
    check("ar_accepted", 32'(done), 32'h1);
    check("rvalid_latency", 32'(axi.S_AXI_RVALID), 32'h1);
    rdata = axi.S_AXI_RDATA;
    rresp = axi.S_AXI_RRESP;
    repeat (rready_dly) begin
      tick();
      check("arready_low_in_r", 32'(axi.S_AXI_ARREADY), 32'h0);
    end
    axi.S_AXI_RREADY = 1'b1;
    tick();
    axi.S_AXI_RREADY = 1'b0;
    check("rvalid_after_r_hs", 32'(axi.S_AXI_RVALID), 32'h0);
    $display("[TB] read addr=%08h rdata=%08h rresp=%0d", addr, rdata, rresp);
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [1:0]  bresp;
    logic        pulse;
    logic [3:0]  idx;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    rst = 1'b1;
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA = '0;  axi.S_AXI_WSTRB = '0; axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_ARADDR = '0; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b0;

    repeat (3) tick();
    check("rst_awready", 32'(axi.S_AXI_AWREADY), 32'h0);
    check("rst_wready", 32'(axi.S_AXI_WREADY), 32'h0);
    check("rst_arready", 32'(axi.S_AXI_ARREADY), 32'h0);
    check("rst_bvalid", 32'(axi.S_AXI_BVALID), 32'h0);
    check("rst_rvalid", 32'(axi.S_AXI_RVALID), 32'h0);
    check("rst_rdata", axi.S_AXI_RDATA, 32'h0);
    check("rst_wr_pulse", 32'(wr_pulse), 32'h0);
    check("rst_wr_index", 32'(wr_index), 32'h0);
    checkv("rst_reg_out", reg_out, '0);
    rst = 1'b0;
    tick();
    check("post_rst_awready", 32'(axi.S_AXI_AWREADY), 32'h1);
    check("post_rst_wready", 32'(axi.S_AXI_WREADY), 32'h1);
    check("post_rst_arready", 32'(axi.S_AXI_ARREADY), 32'h1);

    // AW and W in the same cycle
    axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b0, bresp, pulse, idx);
    check("w1_bresp", 32'(bresp), 32'h0);
    check("w1_pulse", 32'(pulse), 32'h1);
    check("w1_index", 32'(idx), 32'h1);
    check("w1_reg1", reg_out[63:32], 32'hDEADBEEF);

    // W three cycles ahead of AW, partial strobe over a preloaded register
    axi_write(32'h8, 32'hFFFFFFFF, 4'hF, 0, 0, 2, 1'b0, bresp, pulse, idx);
    axi_write(32'h8, 32'h11223344, 4'h5, 3, 0, 0, 1'b1, bresp, pulse, idx);
    check("w2_bresp", 32'(bresp), 32'h0);
    check("w2_reg2", reg_out[95:64], 32'hFF22FF44);

    // Last register with low address bits set, then out-of-range writes
    axi_write(32'h1F, 32'hA5A5A5A5, 4'hF, 1, 0, 1, 1'b0, bresp, pulse, idx);
    check("w3_index", 32'(idx), 32'h7);
    check("w3_reg7", reg_out[255:224], 32'hA5A5A5A5);
    axi_write(32'h20, 32'h12345678, 4'hF, 0, 2, 0, 1'b0, bresp, pulse, idx);
    check("w4_bresp", 32'(bresp), 32'h2);
    check("w4_pulse", 32'(pulse), 32'h0);
    axi_write(32'h80000004, 32'h0BAD0BAD, 4'hF, 0, 0, 0, 1'b0, bresp, pulse, idx);
    check("w5_bresp", 32'(bresp), 32'h2);
    check("w5_reg1", reg_out[63:32], 32'hDEADBEEF);

    axi_read(32'h40, 0, rdata, rresp);
    check("r1_rresp", 32'(rresp), 32'h2);
    check("r1_rdata", rdata, 32'h0);
    axi_read(32'h4, 5, rdata, rresp);
    check("r2_rresp", 32'(rresp), 32'h0);
    check("r2_rdata", rdata, 32'hDEADBEEF);
    axi_read(32'h1C, 1, rdata, rresp);
    check("r3_rdata", rdata, 32'hA5A5A5A5);

    // Commit to reg 3 and AR to 0xC on the same edge
    axi_write(32'hC, 32'h0BADF00D, 4'hF, 0, 0, 0, 1'b0, bresp, pulse, idx);
    axi.S_AXI_AWADDR = 32'hC; axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WDATA = 32'h600DCAFE; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
    tick();
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_ARADDR = 32'hC; axi.S_AXI_ARVALID = 1'b1;
    tick();
    axi.S_AXI_ARVALID = 1'b0;
    check("cc_rvalid", 32'(axi.S_AXI_RVALID), 32'h1);
    check("cc_rdata_old", axi.S_AXI_RDATA, 32'h0BADF00D);
    check("cc_reg3_new", reg_out[127:96], 32'h600DCAFE);
    check("cc_bvalid", 32'(axi.S_AXI_BVALID), 32'h1);
    check("cc_pulse", 32'(wr_pulse), 32'h1);
    check("cc_index", 32'(wr_index), 32'h3);
    axi.S_AXI_BREADY = 1'b1; axi.S_AXI_RREADY = 1'b1;
    tick();
    axi.S_AXI_BREADY = 1'b0; axi.S_AXI_RREADY = 1'b0;
    $display("[TB] concurrent write/read addr=0000000c rdata=%08h", 32'h0BADF00D);

    // Reset while BVALID waits for BREADY
    axi.S_AXI_AWADDR = 32'h10; axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WDATA = 32'h77; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
    tick();
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
    tick();
    check("rb_bvalid_pending", 32'(axi.S_AXI_BVALID), 32'h1);
    tick();
    rst = 1'b1;
    tick();
    check("rb_awready_in_rst", 32'(axi.S_AXI_AWREADY), 32'h0);
    check("rb_arready_in_rst", 32'(axi.S_AXI_ARREADY), 32'h0);
    check("rb_bvalid_cleared", 32'(axi.S_AXI_BVALID), 32'h0);
    checkv("rb_regs_cleared", reg_out, '0);
    rst = 1'b0;
    tick();
    check("rb_awready_after", 32'(axi.S_AXI_AWREADY), 32'h1);
    check("rb_wready_after", 32'(axi.S_AXI_WREADY), 32'h1);
    check("rb_arready_after", 32'(axi.S_AXI_ARREADY), 32'h1);
    $display("[TB] write addr=00000010 abandoned by reset during B phase");

    // Reset during R phase
    axi.S_AXI_ARADDR = 32'h4; axi.S_AXI_ARVALID = 1'b1;
    tick();
    axi.S_AXI_ARVALID = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rr_rvalid_cleared", 32'(axi.S_AXI_RVALID), 32'h0);
    $display("[TB] read addr=00000004 abandoned by reset during R phase");

    // AW held then reset: the later W alone must not commit
    axi.S_AXI_AWADDR = 32'h0; axi.S_AXI_AWVALID = 1'b1;
    tick();
    axi.S_AXI_AWVALID = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    axi.S_AXI_WDATA = 32'h99; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
    tick();
    axi.S_AXI_WVALID = 1'b0;
    repeat (3) tick();
    check("ah_no_bvalid", 32'(axi.S_AXI_BVALID), 32'h0);
    checkv("ah_no_update", reg_out, '0);
    axi.S_AXI_AWADDR = 32'h0; axi.S_AXI_AWVALID = 1'b1;
    tick();
    axi.S_AXI_AWVALID = 1'b0;
    check("ah_bvalid_wait", 32'(axi.S_AXI_BVALID), 32'h0);
    tick();
    check("ah_bvalid", 32'(axi.S_AXI_BVALID), 32'h1);
    check("ah_bresp", 32'(axi.S_AXI_BRESP), 32'h0);
    check("ah_reg0", reg_out[31:0], 32'h99);
    axi.S_AXI_BREADY = 1'b1;
    tick();
    axi.S_AXI_BREADY = 1'b0;
    $display("[TB] write addr=00000000 data=00000099 W before AW after reset, bresp=0");

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_regs.md
AXI4_LITE_SLAVE_REGS -- requirements
Module: axi4_lite_slave_regs

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8: number of 32-bit read/write registers, 1..16.
REQ-002 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have AW channel ports S_AXI_AWADDR input 32, S_AXI_AWVALID input 1, S_AXI_AWREADY output 1.
REQ-005 SHALL have W channel ports S_AXI_WDATA input 32, S_AXI_WSTRB input 4, S_AXI_WVALID input 1, S_AXI_WREADY output 1.
REQ-006 SHALL have B channel ports S_AXI_BRESP output 2, S_AXI_BVALID output 1, S_AXI_BREADY input 1.
REQ-007 SHALL have AR channel ports S_AXI_ARADDR input 32, S_AXI_ARVALID input 1, S_AXI_ARREADY output 1.
REQ-008 SHALL have R channel ports S_AXI_RDATA output 32, S_AXI_RRESP output 2, S_AXI_RVALID output 1, S_AXI_RREADY input 1.
REQ-009 SHALL have port Reg_Out, output, NUM_REGS*32 bits: register i on bits [32*i+31:32*i].
REQ-010 SHALL have ports Wr_Pulse output 1 and Wr_Index output 4: one-cycle strobe and register index of each committed write.

Function
REQ-011 Decode: index = addr[5:2]; address in range iff addr < NUM_REGS*4 (full 32-bit compare); addr[1:0] ignored.
REQ-012 Write path states: W_COLLECT (gathering AW and W), W_RESP (BVALID high).
REQ-013 W_COLLECT: S_AXI_AWREADY = !aw_held && !rst; S_AXI_WREADY = !w_held && !rst; AW and W accepted independently, in either order or same cycle.
REQ-014 AW handshake latches address and sets aw_held; W handshake latches data/strobe and sets w_held.
REQ-015 On the first edge where aw_held && w_held: commit write, clear both flags, enter W_RESP with BVALID=1.
REQ-016 Latency: both handshakes at edge N -> register updated and BVALID=1 after edge N+1.
REQ-017 Commit in range: byte k of register updated only if WSTRB[k]=1; BRESP=2'b00; Wr_Pulse=1 and Wr_Index=index for exactly that cycle.
REQ-018 Commit out of range: no register changes, Wr_Pulse stays 0, BRESP=2'b10 (SLVERR).
REQ-019 W_RESP: AWREADY=WREADY=0; BVALID, BRESP held stable until BREADY=1; on BVALID&&BREADY edge return to W_COLLECT.
REQ-020 Read path states: R_IDLE (ARREADY = !rst), R_DATA (RVALID high, ARREADY=0).
REQ-021 AR handshake at edge N: RDATA/RRESP registered from current register values, RVALID=1 after edge N.
REQ-022 Read in range: RDATA = register, RRESP=2'b00; out of range: RDATA=0, RRESP=2'b10.
REQ-023 RDATA, RRESP, RVALID held stable until RREADY=1; on RVALID&&RREADY edge return to R_IDLE.
REQ-024 Read and write paths operate concurrently and independently.
REQ-025 Read captured on same edge as write commit to same register returns pre-write value.
REQ-026 BREADY/RREADY held high early have no effect before the corresponding VALID is high.
REQ-027 Reg_Out reflects register contents combinationally from the registers, updated the edge after commit.

Reset
REQ-028 While rst=1, all ready outputs SHALL be 0.
REQ-029 On an edge with rst=1: all registers = 0; aw_held = w_held = 0; BVALID = RVALID = 0; BRESP = RRESP = 0; RDATA = 0; Wr_Pulse = 0; Wr_Index = 0.
REQ-030 Reset mid-transaction SHALL abandon it, with no partial register update and no BVALID/RVALID after reset releases.
REQ-031 The cycle after rst deasserts, AWREADY=WREADY=ARREADY=1.

Verification
REQ-032 AW addr 0x4 and W data 0xDEADBEEF, strb 0xF, same cycle -> BVALID next cycle, BRESP=00, Wr_Pulse with Wr_Index=1, Reg_Out[63:32]=0xDEADBEEF.
REQ-033 W (0x11223344, strb 0x5) three cycles before AW addr 0x8, register 2 preloaded 0xFFFFFFFF -> register 2 = 0xFF22FF44, one BVALID.
REQ-034 Write to 0x20 and read 0x40 (NUM_REGS=8) -> BRESP=10 with no register change; RRESP=10 with RDATA=0.
REQ-035 Read 0x4 with RREADY low 5 cycles -> RVALID and RDATA=0xDEADBEEF stable, ARREADY=0 throughout; single R handshake.
REQ-036 Write commit to reg 3 on same edge as AR to 0xC -> RDATA = old value, Reg_Out shows new value.
REQ-037 rst pulsed while BVALID=1 awaiting BREADY -> BVALID=0, all registers 0, readies high the cycle after release.
